vector_operand_collector: RTL

//  Read-side client of the VEGGIE vector register file. Accepts one issued vector op, drives

---
 rtl/vector_operand_collector_pkg.sv | 38 +++
 rtl/vector_operand_collector_if.sv | 56 +++++
 rtl/vector_operand_collector_slot.sv | 48 ++++
 rtl/vector_operand_collector.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vector_operand_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vector_operand_collector_pkg
// Brief    : Types and sizes shared by the vector operand collector slice.
// Revision : 1.0 - initial release
// ============================================================================
package vector_operand_collector_pkg;

    localparam int VLMAX    = 32;
    localparam int ESZ      = 16;
    localparam int VREG_W   = VLMAX * ESZ;
    localparam int VIDX_W   = 8;
    localparam int MASK_IDX = 4;
    localparam int STALL_W  = 16;

    typedef logic [VIDX_W-1:0]   vsel_t;
    typedef logic [MASK_IDX-1:0] mask_sel_t;
    typedef logic [VREG_W-1:0]   vreg_t;
    typedef logic [VLMAX-1:0]    vmask_t;

    typedef enum logic [1:0] {
        OPC_IDLE = 2'd0,
        OPC_REQ  = 2'd1,
        OPC_WAIT = 2'd2,
        OPC_OUT  = 2'd3
    } opc_state_t;

    typedef struct packed {
        vsel_t     vs1;
        vsel_t     vs2;
        logic      use_vs2;
        logic      vm;
        mask_sel_t vms;
        vsel_t     vd;
    } opc_issue_t;

endpackage
`default_nettype wire

// File: rtl/vector_operand_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_operand_collector_if
// Brief    : Issue, VEGGIE read and lane-bundle buses of the operand collector.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_operand_collector_if;
    import vector_operand_collector_pkg::*;

    logic               issue_valid;
    logic               issue_ready;
    vsel_t              issue_vs1;
    vsel_t              issue_vs2;
    logic               issue_use_vs2;
    logic               issue_vm;
    mask_sel_t          issue_vms;
    vsel_t              issue_vd;

    vsel_t [1:0]        vg_vs;
    logic  [1:0]        vg_ren;
    mask_sel_t          vg_vms;
    logic               vg_mren;
    logic               vg_ready;
    vreg_t [1:0]        vg_vreg;
    logic  [1:0]        vg_dvalid;
    vmask_t             vg_vmask;
    logic               vg_mvalid;

    logic               op_valid;
    logic               op_ready;
    vreg_t              op_v1;
    vreg_t              op_v2;
    vmask_t             op_vmask;
    vsel_t              op_vd;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        input  issue_valid, issue_vs1, issue_vs2, issue_use_vs2, issue_vm, issue_vms, issue_vd,
        output issue_ready,
        output vg_vs, vg_ren, vg_vms, vg_mren,
        input  vg_ready, vg_vreg, vg_dvalid, vg_vmask, vg_mvalid,
        output op_valid, op_v1, op_v2, op_vmask, op_vd, stall_cnt,
        input  op_ready
    );

    modport slave (
        output issue_valid, issue_vs1, issue_vs2, issue_use_vs2, issue_vm, issue_vms, issue_vd,
        input  issue_ready,
        input  vg_vs, vg_ren, vg_vms, vg_mren,
        output vg_ready, vg_vreg, vg_dvalid, vg_vmask, vg_mvalid,
        input  op_valid, op_v1, op_v2, op_vmask, op_vd, stall_cnt,
        output op_ready
    );

endinterface
`default_nettype wire

// File: rtl/vector_operand_collector_slot.sv
`default_nettype none
// ============================================================================
// Module   : vector_operand_collector_slot
// Brief    : One operand capture register with its captured flag.
// Revision : 1.0 - initial release
// ============================================================================
module vector_operand_collector_slot #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_preload,
    input  logic             i_need,
    input  logic             i_capture_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_pending,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data
);

    logic             r_captured;
    logic [WIDTH-1:0] r_data;
    logic             w_hit;

    // Only the first return for a needed slot is kept; later ones are stray.
    assign w_hit = i_capture_en & i_valid & i_need & ~r_captured;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_captured <= 1'b0;
            r_data     <= '0;
        end else if (i_load) begin
            r_captured <= 1'b0;
            r_data     <= i_preload;
        end else if (w_hit) begin
            r_captured <= 1'b1;
            r_data     <= i_data;
        end
    end

    assign o_pending = i_need & ~r_captured;
    assign o_done    = ~i_need | r_captured | w_hit;
    assign o_data    = r_data;

endmodule
`default_nettype wire

// File: rtl/vector_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : vector_operand_collector
// Brief    : Requests VEGGIE operands for one op and hands the bundle to lanes.
// Revision : 1.0 - initial release
// ============================================================================
module vector_operand_collector
    import vector_operand_collector_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    vector_operand_collector_if.master opc
);

    localparam logic [STALL_W-1:0] c_stall_max = '1;

    opc_state_t         r_state;
    opc_state_t         w_state_next;
    opc_issue_t         r_issue;
    opc_issue_t         w_issue;
    logic               w_issue_ready;
    logic               w_accept;
    logic               w_capture_en;
    logic               w_all_done;
    logic               w_in_req;
    logic [STALL_W-1:0] r_stall;

    logic [1:0]         w_data_need;
    logic [1:0]         w_data_pending;
    logic [1:0]         w_data_done;
    vreg_t              w_data [2];
    logic               w_mask_pending;
    logic               w_mask_done;
    vmask_t             w_mask;

    assign w_issue = '{vs1:     opc.issue_vs1,
                       vs2:     opc.issue_vs2,
                       use_vs2: opc.issue_use_vs2,
                       vm:      opc.issue_vm,
                       vms:     opc.issue_vms,
                       vd:      opc.issue_vd};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OPC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_issue_ready = 1'b0;
        w_capture_en  = 1'b0;
        case (r_state)
            OPC_IDLE: begin
                w_issue_ready = 1'b1;
                if (opc.issue_valid) w_state_next = OPC_REQ;
            end
            OPC_REQ: begin
                if (opc.vg_ready) w_state_next = OPC_WAIT;
            end
            OPC_WAIT: begin
                w_capture_en = 1'b1;
                if (w_all_done) w_state_next = OPC_OUT;
            end
            OPC_OUT: begin
                // A back-to-back op is taken on the same edge the bundle retires.
                w_issue_ready = opc.op_ready;
                if (opc.op_ready) begin
                    w_state_next = opc.issue_valid ? OPC_REQ : OPC_IDLE;
                end
            end
            default: w_state_next = OPC_IDLE;
        endcase
    end

    assign w_accept = w_issue_ready & opc.issue_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue <= '0;
        end else if (w_accept) begin
            r_issue <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == OPC_WAIT) && (r_stall != c_stall_max)) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    // Need flags come from the latched issue fields, so they are stable for the whole op.
    assign w_data_need = {r_issue.use_vs2, 1'b1};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_data_slot
            vector_operand_collector_slot #(
                .WIDTH (VREG_W)
            ) u_slot (
                .clk          (clk),
                .rst          (rst),
                .i_load       (w_accept),
                .i_preload    ('0),
                .i_need       (w_data_need[p]),
                .i_capture_en (w_capture_en),
                .i_valid      (opc.vg_dvalid[p]),
                .i_data       (opc.vg_vreg[p]),
                .o_pending    (w_data_pending[p]),
                .o_done       (w_data_done[p]),
                .o_data       (w_data[p])
            );
        end
    endgenerate

    vector_operand_collector_slot #(
        .WIDTH (VLMAX)
    ) u_mask_slot (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_preload    ('1),
        .i_need       (r_issue.vm),
        .i_capture_en (w_capture_en),
        .i_valid      (opc.vg_mvalid),
        .i_data       (opc.vg_vmask),
        .o_pending    (w_mask_pending),
        .o_done       (w_mask_done),
        .o_data       (w_mask)
    );

    assign w_all_done = (&w_data_done) & w_mask_done;
    assign w_in_req   = (r_state == OPC_REQ);

    assign opc.issue_ready = w_issue_ready;
    assign opc.vg_ren      = w_in_req ? w_data_pending : 2'b00;
    assign opc.vg_vs       = w_in_req ? {r_issue.vs2, r_issue.vs1} : '0;
    assign opc.vg_mren     = w_in_req & w_mask_pending;
    assign opc.vg_vms      = w_in_req ? r_issue.vms : '0;
    assign opc.op_valid    = (r_state == OPC_OUT);
    assign opc.op_v1       = w_data[0];
    assign opc.op_v2       = w_data[1];
    assign opc.op_vmask    = w_mask;
    assign opc.op_vd       = r_issue.vd;
    assign opc.stall_cnt   = r_stall;

endmodule
`default_nettype wire
